// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a registered read port, an explicit occupancy counter,
// threshold flags and one-cycle overflow/underflow pulses.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrEn,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rdEn,
  output logic [DATA_W-1:0]          dout,
  output logic                       rdValid,
  output logic                       fifoFull,
  output logic                       fifoEmpty,
  output logic                       almostFull,
  output logic                       almostEmpty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              wrAccept;
  logic              rdAccept;

  // A full FIFO still takes a write when a read frees a slot in the same edge.
  assign wrAccept = wrEn && (!fifoFull || rdEn);
  assign rdAccept = rdEn && !fifoEmpty;

  assign fifoFull    = (count == FULL_C);
  assign fifoEmpty   = (count == '0);
  assign almostFull  = (count >= AF_C);
  assign almostEmpty = (count <= AE_C);

  always_ff @(posedge clk) begin
    if (wrAccept) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      dout      <= '0;
      rdValid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rdValid   <= rdAccept;
      overflow  <= wrEn && fifoFull && !rdEn;
      underflow <= rdEn && fifoEmpty;
      if (wrAccept) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (rdAccept) begin
        dout  <= mem[rdPtr];
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({wrAccept, rdAccept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: queue-based reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wrEn = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdEn = 1'b0;
  logic [7:0] dout;
  logic       rdValid, fifoFull, fifoEmpty, almostFull, almostEmpty;
  logic [4:0] count;
  logic       overflow, underflow;

  int nChecks = 0;
  int nPass   = 0;

  param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .din(din), .rdEn(rdEn),
    .dout(dout), .rdValid(rdValid), .fifoFull(fifoFull), .fifoEmpty(fifoEmpty),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, flags derived from its size.
  logic [7:0] q[$];
  logic [7:0] mDout  = 8'h00;
  logic       mValid = 1'b0;
  logic       mOvf   = 1'b0;
  logic       mUnf   = 1'b0;

  always @(posedge clk or negedge rst) begin
    bit doRd, doWr, wasFull, wasEmpty;
    if (!rst) begin
      q.delete();
      mDout  <= 8'h00;
      mValid <= 1'b0;
      mOvf   <= 1'b0;
      mUnf   <= 1'b0;
    end else begin
      wasFull  = (q.size() == 16);
      wasEmpty = (q.size() == 0);
      doRd = rdEn && !wasEmpty;
      doWr = wrEn && (!wasFull || rdEn);
      mValid <= doRd;
      mOvf   <= wrEn && wasFull && !rdEn;
      mUnf   <= rdEn && wasEmpty;
      if (doRd) begin
        mDout <= q[0];
        void'(q.pop_front());
      end
      if (doWr) q.push_back(din);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    else
      nPass++;
  endtask

  always @(negedge clk) begin
    int sz;
    sz = q.size();
    checkOutput("model.count",       32'(count),       32'(sz));
    checkOutput("model.dout",        32'(dout),        32'(mDout));
    checkOutput("model.rdValid",     32'(rdValid),     32'(mValid));
    checkOutput("model.overflow",    32'(overflow),    32'(mOvf));
    checkOutput("model.underflow",   32'(underflow),   32'(mUnf));
    checkOutput("model.fifoFull",    32'(fifoFull),    32'(sz == 16));
    checkOutput("model.fifoEmpty",   32'(fifoEmpty),   32'(sz == 0));
    checkOutput("model.almostFull",  32'(almostFull),  32'(sz >= 14));
    checkOutput("model.almostEmpty", 32'(almostEmpty), 32'(sz <= 2));
  end

  // Drive one cycle of inputs, return just after the edge that samples them.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
    wrEn = w;
    din  = d;
    rdEn = r;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    #1 rst = 1'b0;
    #1;
    checkOutput("reset.count",       32'(count),       32'd0);
    checkOutput("reset.fifoEmpty",   32'(fifoEmpty),   32'd1);
    checkOutput("reset.almostEmpty", 32'(almostEmpty), 32'd1);
    checkOutput("reset.fifoFull",    32'(fifoFull),    32'd0);
    checkOutput("reset.almostFull",  32'(almostFull),  32'd0);
    checkOutput("reset.dout",        32'(dout),        32'd0);
    checkOutput("reset.rdValid",     32'(rdValid),     32'd0);

    // Requests during reset must be ignored.
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("inReset.count", 32'(count), 32'd0);
    #3 rst = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == 2)  checkOutput("thr.ae_at2",  32'(almostEmpty), 32'd1);
      if (i == 3)  checkOutput("thr.ae_at3",  32'(almostEmpty), 32'd0);
      if (i == 13) checkOutput("thr.af_at13", 32'(almostFull),  32'd0);
      if (i == 14) checkOutput("thr.af_at14", 32'(almostFull),  32'd1);
    end
    checkOutput("fill.count", 32'(count),    32'd16);
    checkOutput("fill.full",  32'(fifoFull), 32'd1);

    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("ovf.pulse", 32'(overflow), 32'd1);
    checkOutput("ovf.count", 32'(count),    32'd16);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf.clear", 32'(overflow), 32'd0);

    applyStimulus(1'b1, 8'h11, 1'b1);
    checkOutput("fullRW.count",    32'(count),    32'd16);
    checkOutput("fullRW.overflow", 32'(overflow), 32'd0);
    checkOutput("fullRW.dout",     32'(dout),     32'h01);

    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("drain.rdValid", 32'(rdValid), 32'd1);
      checkOutput("drain.dout",    32'(dout),    (k == 16) ? 32'h11 : 32'(k + 1));
      if (k == 3) checkOutput("thr.af_drop", 32'(almostFull), 32'd0);
    end
    checkOutput("drain.empty", 32'(fifoEmpty), 32'd1);

    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("unf.pulse",   32'(underflow), 32'd1);
    checkOutput("unf.dout",    32'(dout),      32'h11);
    checkOutput("unf.rdValid", 32'(rdValid),   32'd0);
    applyStimulus(1'b1, 8'h5C, 1'b1);
    checkOutput("emptyRW.count", 32'(count),     32'd1);
    checkOutput("emptyRW.unf",   32'(underflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("emptyRW.dout",  32'(dout),      32'h5C);
    checkOutput("emptyRW.unf0",  32'(underflow), 32'd0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(i + 5), 1'b1);
      checkOutput("wrap.dout",  32'(dout),  32'(i));
      checkOutput("wrap.count", 32'(count), 32'd5);
    end

    for (int i = 45; i < 50; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("preRst.dout",  32'(dout),  32'd40);
    checkOutput("preRst.count", 32'(count), 32'd9);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRst.count",     32'(count),       32'd0);
    checkOutput("midRst.dout",      32'(dout),        32'd0);
    checkOutput("midRst.rdValid",   32'(rdValid),     32'd0);
    checkOutput("midRst.empty",     32'(fifoEmpty),   32'd1);
    checkOutput("midRst.aEmpty",    32'(almostEmpty), 32'd1);
    checkOutput("midRst.full",      32'(fifoFull),    32'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postRst.unf",     32'(underflow), 32'd1);
    checkOutput("postRst.rdValid", 32'(rdValid),   32'd0);

    applyStimulus(1'b0, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, data width in bits (legal range 1..64).
REQ-002 The module SHALL have parameter DEPTH, default 16, number of entries (power of two, at least 4).
REQ-003 The module SHALL have parameter AF_THRESH, default DEPTH-2, almostFull asserts when count >= AF_THRESH.
REQ-004 The module SHALL have parameter AE_THRESH, default 2, almostEmpty asserts when count <= AE_THRESH.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-007 The module SHALL have port wrEn, input, 1 bit, write request.
REQ-008 The module SHALL have port din, input, DATA_W bits, write data, sampled when wrEn is high.
REQ-009 The module SHALL have port rdEn, input, 1 bit, read request.
REQ-010 The module SHALL have port dout, output, DATA_W bits, registered read data.
REQ-011 The module SHALL have port rdValid, output, 1 bit, dout updated this cycle (one-cycle pulse).
REQ-012 The module SHALL have port fifoFull, output, 1 bit, asserted when count == DEPTH.
REQ-013 The module SHALL have port fifoEmpty, output, 1 bit, asserted when count == 0.
REQ-014 The module SHALL have port almostFull, output, 1 bit, asserted when count >= AF_THRESH.
REQ-015 The module SHALL have port almostEmpty, output, 1 bit, asserted when count <= AE_THRESH.
REQ-016 The module SHALL have port count, output, $clog2(DEPTH)+1 bits, current occupancy in the range 0..DEPTH.
REQ-017 The module SHALL have port overflow, output, 1 bit, one-cycle pulse flagging a rejected write.
REQ-018 The module SHALL have port underflow, output, 1 bit, one-cycle pulse flagging a rejected read.

Function
REQ-019 A write SHALL be accepted when wrEn && (!fifoFull || rdEn); din is stored at wrPtr and wrPtr advances by 1, wrapping from DEPTH-1 to 0.
REQ-020 A read SHALL be accepted when rdEn && !fifoEmpty; mem[rdPtr] is loaded into dout at the same edge, rdValid is 1 in the following cycle, and rdPtr advances with wrap.
REQ-021 Read latency SHALL be one clock: rdEn sampled at edge N drives dout and rdValid valid after edge N.
REQ-022 dout SHALL hold its last value when no read is accepted.
REQ-023 Write-only accepted: count +1; read-only accepted: count -1; both accepted: count unchanged.
REQ-024 When full with wrEn and rdEn both high, both SHALL be accepted, count stays DEPTH, and overflow SHALL remain 0.
REQ-025 When empty with wrEn and rdEn both high, only the write SHALL be accepted (no fall-through), count becomes 1, and underflow pulses 1.
REQ-026 overflow SHALL be 1 for one cycle after an edge where wrEn && fifoFull && !rdEn; the FIFO contents remain unchanged.
REQ-027 underflow SHALL be 1 for one cycle after an edge where rdEn && fifoEmpty; dout and rdPtr remain unchanged.
REQ-028 fifoFull, fifoEmpty, almostFull and almostEmpty SHALL be decoded from registered count and SHALL reflect the post-edge count in the same cycle.
REQ-029 Pointers SHALL be $clog2(DEPTH) bits wide, and count SHALL be held as an explicit register, never derived from pointer difference.
REQ-030 Data SHALL emerge in strict write order across any number of pointer wrap-arounds.

Reset
REQ-031 While rst is 0, and immediately on its falling edge: wrPtr=0, rdPtr=0, count=0, dout=0, rdValid=0, overflow=0, underflow=0, fifoEmpty=1, almostEmpty=1, fifoFull=0, almostFull=0.
REQ-032 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-033 wrEn and rdEn SHALL be ignored while rst is 0, and the first accepted operation SHALL occur at the first rising clk edge after rst deasserts.

Verification (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
REQ-034 Fill/drain: write 0x01..0x10 -> fifoFull=1, count=16; then read 16 -> dout 0x01..0x10 in order with rdValid on each, and fifoEmpty=1 at the end.
REQ-035 Thresholds: write 3 -> almostEmpty drops to 0 at count=3; write to count=14 -> almostFull=1; read 1 -> almostFull=0.
REQ-036 Overflow: at count=16, wrEn=1, rdEn=0 with din=0xAA -> overflow pulse, count=16, and 0xAA never read; at full with wrEn=1 and rdEn=1 -> count stays 16 and overflow=0.
REQ-037 Underflow and empty simultaneous: empty with rdEn=1 -> underflow pulse and dout unchanged; empty with wrEn=1, rdEn=1, din=0x5C -> count=1, underflow pulse, and next read returns 0x5C.
REQ-038 Wrap: 40 cycles of simultaneous read and write at count=5 with an incrementing pattern -> no data loss, order preserved, count constant at 5.
REQ-039 Reset mid-operation: at count=9, pulse rst low asynchronously between clock edges -> all flags, count and outputs take their reset values immediately, and the next read attempt gives underflow=1.
